onewire_slave: RTL and testbench

- Single-drop 1-wire responder (DS18B20-style subset) for the same open-drain bus the team's 1-wire master drives.
- Detects bus reset and answers with a presence pulse.
- Receives function-command bytes LSB first in write slots:
  - 44h requests a conversion.
  - BEh returns a 16-bit data word LSB first in the master's read slots.
- Serves as bench counterpart for the master and as an on-chip device model.

---
 rtl/onewire_slave.sv | 198 +++++++++++++++++++
 tb/tb_onewire_slave.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/onewire_slave.sv
// Single-drop 1-wire responder: presence on bus reset, command byte receive,
// conversion request on 44h, and a 16-bit data word returned after BEh.
module onewire_slave #(
  parameter int CLK_PER_US   = 100,
  parameter int RST_MIN_US   = 400,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LEN_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int TX_HOLD_US   = 30
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         dq,
  input  logic [15:0] data_in,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        convert_req,
  output logic        presence_active,
  output logic        tx_active
);

  localparam logic [19:0] RST_CYC       = 20'(RST_MIN_US * CLK_PER_US);
  localparam logic [19:0] PRES_WAIT_CYC = 20'(PRES_WAIT_US * CLK_PER_US);
  localparam logic [19:0] PRES_LEN_CYC  = 20'(PRES_LEN_US * CLK_PER_US);
  localparam logic [19:0] SAMPLE_CYC    = 20'(SAMPLE_US * CLK_PER_US);
  localparam logic [19:0] TX_HOLD_CYC   = 20'(TX_HOLD_US * CLK_PER_US);

  typedef enum logic [2:0] {IDLE, PRES_WAIT, PRES_DRIVE, RX_CMD, TX_DATA} state_t;

  state_t      state_reg, state_next;
  logic        dq_meta_reg, dq_s_reg, dq_prev_reg;
  logic [19:0] low_cnt_reg, low_cnt_next;
  logic [19:0] timer_reg, timer_next;
  logic [3:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [15:0] tx_shift_reg, tx_shift_next;
  logic [7:0]  cmd_byte_reg, cmd_byte_next;
  logic        cmd_valid_reg, cmd_valid_next;
  logic        convert_req_reg, convert_req_next;
  logic        drive_reg, drive_next;
  logic        slot_active_reg, slot_active_next;
  logic        fall, rise, rst_class;
  logic [7:0]  rx_byte;

  // Reset also gates the driver so the bus is released without waiting for a clock.
  assign dq = (drive_reg && !reset) ? 1'b0 : 1'bz;

  assign fall      = dq_prev_reg & ~dq_s_reg;
  assign rise      = ~dq_prev_reg & dq_s_reg;
  assign rst_class = rise && (low_cnt_reg >= RST_CYC);
  assign rx_byte   = {dq_s_reg, rx_shift_reg[6:0]};

  // Low time is frozen while we pull the line ourselves so our own low never looks like a reset.
  always_comb begin
    low_cnt_next = low_cnt_reg;
    if (fall)
      low_cnt_next = 20'd1;
    else if (!dq_s_reg && !drive_reg && low_cnt_reg != 20'hFFFFF)
      low_cnt_next = low_cnt_reg + 20'd1;
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    bit_idx_next     = bit_idx_reg;
    rx_shift_next    = rx_shift_reg;
    tx_shift_next    = tx_shift_reg;
    cmd_byte_next    = cmd_byte_reg;
    cmd_valid_next   = 1'b0;
    convert_req_next = 1'b0;
    drive_next       = drive_reg;
    slot_active_next = slot_active_reg;
    if (rst_class) begin
      state_next       = PRES_WAIT;
      timer_next       = '0;
      bit_idx_next     = '0;
      rx_shift_next    = '0;
      tx_shift_next    = '0;
      drive_next       = 1'b0;
      slot_active_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin end
        PRES_WAIT: begin
          if (timer_reg == PRES_WAIT_CYC - 20'd1) begin
            state_next = PRES_DRIVE;
            timer_next = '0;
            drive_next = 1'b1;
          end else begin
            timer_next = timer_reg + 20'd1;
          end
        end
        PRES_DRIVE: begin
          if (timer_reg == PRES_LEN_CYC - 20'd1) begin
            state_next       = RX_CMD;
            timer_next       = '0;
            drive_next       = 1'b0;
            bit_idx_next     = '0;
            slot_active_next = 1'b0;
          end else begin
            timer_next = timer_reg + 20'd1;
          end
        end
        RX_CMD: begin
          // A new falling edge always restarts the slot, discarding any unsampled bit.
          if (fall) begin
            slot_active_next = 1'b1;
            timer_next       = 20'd1;
          end else if (slot_active_reg) begin
            if (timer_reg == SAMPLE_CYC) begin
              slot_active_next = 1'b0;
              timer_next       = '0;
              rx_shift_next[bit_idx_reg[2:0]] = dq_s_reg;
              if (bit_idx_reg == 4'd7) begin
                bit_idx_next   = '0;
                cmd_byte_next  = rx_byte;
                cmd_valid_next = 1'b1;
                if (rx_byte == 8'h44) begin
                  convert_req_next = 1'b1;
                end else if (rx_byte == 8'hBE) begin
                  tx_shift_next = data_in;
                  state_next    = TX_DATA;
                end
              end else begin
                bit_idx_next = bit_idx_reg + 4'd1;
              end
            end else begin
              timer_next = timer_reg + 20'd1;
            end
          end
        end
        TX_DATA: begin
          if (fall && !drive_reg) begin
            slot_active_next = 1'b1;
            timer_next       = 20'd1;
            drive_next       = ~tx_shift_reg[bit_idx_reg];
          end else if (slot_active_reg) begin
            if (timer_reg == TX_HOLD_CYC) begin
              drive_next       = 1'b0;
              slot_active_next = 1'b0;
              timer_next       = '0;
              if (bit_idx_reg == 4'd15) begin
                state_next   = IDLE;
                bit_idx_next = '0;
              end else begin
                bit_idx_next = bit_idx_reg + 4'd1;
              end
            end else begin
              timer_next = timer_reg + 20'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      dq_meta_reg     <= 1'b1;
      dq_s_reg        <= 1'b1;
      dq_prev_reg     <= 1'b1;
      low_cnt_reg     <= '0;
      timer_reg       <= '0;
      bit_idx_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      cmd_byte_reg    <= '0;
      cmd_valid_reg   <= 1'b0;
      convert_req_reg <= 1'b0;
      drive_reg       <= 1'b0;
      slot_active_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dq_meta_reg     <= dq;
      dq_s_reg        <= dq_meta_reg;
      dq_prev_reg     <= dq_s_reg;
      low_cnt_reg     <= low_cnt_next;
      timer_reg       <= timer_next;
      bit_idx_reg     <= bit_idx_next;
      rx_shift_reg    <= rx_shift_next;
      tx_shift_reg    <= tx_shift_next;
      cmd_byte_reg    <= cmd_byte_next;
      cmd_valid_reg   <= cmd_valid_next;
      convert_req_reg <= convert_req_next;
      drive_reg       <= drive_next;
      slot_active_reg <= slot_active_next;
    end
  end

  assign cmd_byte        = cmd_byte_reg;
  assign cmd_valid       = cmd_valid_reg;
  assign convert_req     = convert_req_reg;
  assign presence_active = (state_reg == PRES_DRIVE);
  assign tx_active       = (state_reg == TX_DATA);

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: the bench plays the bus master on a pulled-up line.
`timescale 1ns/1ps
module tb_onewire_slave;
  localparam int US = 10;  // DUT runs at 10 clk per us to keep runs short

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        master_low = 1'b0;
  logic [15:0] data_in = 16'h0000;
  wire         dq;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, convert_req, presence_active, tx_active;

  pullup (dq);
  assign dq = master_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  onewire_slave #(.CLK_PER_US(US)) dut (
    .clk(clk), .reset(reset), .dq(dq), .data_in(data_in),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .convert_req(convert_req),
    .presence_active(presence_active), .tx_active(tx_active)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int cv_cnt = 0, cr_cnt = 0, pres_cycles = 0, pres_rises = 0, pres_rise_cyc = 0;
  logic pres_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (convert_req) cr_cnt <= cr_cnt + 1;
    if (presence_active) pres_cycles <= pres_cycles + 1;
    if (presence_active && !pres_prev) begin
      pres_rises    <= pres_rises + 1;
      pres_rise_cyc <= cyc;
    end
    pres_prev <= presence_active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_low(input int n);
    @(negedge clk);
    master_low = 1'b1;
    wait_cyc(n);
    master_low = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic bus_reset_full();
    bus_low(480 * US);
    wait_cyc(303 + 1200 + 20 * US);
  endtask

  task automatic write_bit(input logic b);
    @(negedge clk);
    master_low = 1'b1;
    if (b) begin
      wait_cyc(15 * US);
      master_low = 1'b0;
      wait_cyc(50 * US);
    end else begin
      wait_cyc(60 * US);
      master_low = 1'b0;
      wait_cyc(5 * US);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    @(negedge clk);
    master_low = 1'b1;
    wait_cyc(15 * US);
    master_low = 1'b0;
    wait_cyc(1 * US);
    b = dq;
    wait_cyc(55 * US);
  endtask

  initial begin
    int cv0, cr0, pc0, pr0, d;
    logic b;
    logic [15:0] exp_bits;

    // Reset state
    wait_cyc(5);
    check("rst_cmd_byte", 32'(cmd_byte), 32'h00);
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_convert_req", 32'(convert_req), 32'h0);
    check("rst_presence", 32'(presence_active), 32'h0);
    check("rst_tx_active", 32'(tx_active), 32'h0);
    check("rst_dq_released", 32'(dq), 32'h1);
    reset = 1'b0;
    wait_cyc(10);

    // 300 us low in IDLE: no presence
    pr0 = pres_rises;
    bus_low(300 * US);
    wait_cyc(2000);
    check("short_low_no_presence", 32'(pres_rises - pr0), 32'd0);

    // 480 us bus reset and presence pulse
    pr0 = pres_rises;
    pc0 = pres_cycles;
    bus_low(480 * US);
    wait_cyc(303 + 600);
    check("pres_mid_active", 32'(presence_active), 32'h1);
    check("pres_mid_dq_low", 32'(dq), 32'h0);
    wait_cyc(600 + 50);
    check("pres_after_inactive", 32'(presence_active), 32'h0);
    check("pres_after_dq_released", 32'(dq), 32'h1);
    check("pres_count", 32'(pres_rises - pr0), 32'd1);
    check("pres_len", 32'(pres_cycles - pc0), 32'd1200);
    d = pres_rise_cyc - (rel_cyc + 2);
    checks++;
    assert (d >= 298 && d <= 302) else begin
      errors++;
      $error("FAIL pres_delay observed %0d expected 300+-2", d);
    end
    wait_cyc(20 * US);

    // Convert command 44h
    cv0 = cv_cnt;
    cr0 = cr_cnt;
    write_byte(8'h44);
    check("cvt_cmd_byte", 32'(cmd_byte), 32'h44);
    check("cvt_cmd_valid_pulses", 32'(cv_cnt - cv0), 32'd1);
    check("cvt_convert_pulses", 32'(cr_cnt - cr0), 32'd1);
    check("cvt_tx_idle", 32'(tx_active), 32'h0);

    // Read command BEh then 16 read slots
    data_in = 16'hA5C3;
    cv0 = cv_cnt;
    cr0 = cr_cnt;
    write_byte(8'hBE);
    check("rd_cmd_byte", 32'(cmd_byte), 32'hBE);
    check("rd_cmd_valid_pulses", 32'(cv_cnt - cv0), 32'd1);
    check("rd_no_convert", 32'(cr_cnt - cr0), 32'd0);
    check("rd_tx_active", 32'(tx_active), 32'h1);
    exp_bits = 16'b1010_0101_1100_0011;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("rd_tx_active_before_last", 32'(tx_active), 32'h1);
      read_bit(b);
      check($sformatf("rd_bit%0d", i), 32'(b), 32'(exp_bits[i]));
    end
    check("rd_tx_done", 32'(tx_active), 32'h0);

    // Reset in the middle of a command byte
    bus_reset_full();
    cv0 = cv_cnt;
    cr0 = cr_cnt;
    pr0 = pres_rises;
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    bus_reset_full();
    check("mid_no_cmd_valid", 32'(cv_cnt - cv0), 32'd0);
    check("mid_presence_again", 32'(pres_rises - pr0), 32'd1);
    write_byte(8'h5A);
    check("mid_fresh_byte", 32'(cmd_byte), 32'h5A);
    check("mid_fresh_valid", 32'(cv_cnt - cv0), 32'd1);
    check("mid_no_convert", 32'(cr_cnt - cr0), 32'd0);

    // Asynchronous reset during the presence drive
    bus_low(480 * US);
    wait_cyc(303 + 600);
    check("ar_presence_before", 32'(presence_active), 32'h1);
    reset = 1'b1;
    #1;
    check("ar_dq_released", 32'(dq), 32'h1);
    check("ar_presence", 32'(presence_active), 32'h0);
    check("ar_cmd_byte", 32'(cmd_byte), 32'h00);
    check("ar_cmd_valid", 32'(cmd_valid), 32'h0);
    check("ar_convert_req", 32'(convert_req), 32'h0);
    check("ar_tx_active", 32'(tx_active), 32'h0);
    wait_cyc(5);
    reset = 1'b0;
    pr0 = pres_rises;
    cv0 = cv_cnt;
    wait_cyc(2000);
    write_byte(8'h44);
    check("ar_idle_no_presence", 32'(pres_rises - pr0), 32'd0);
    check("ar_idle_ignores_slots", 32'(cv_cnt - cv0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
